multicycle_controller: RTL and testbench

//  Control unit for the multicycle 32-bit ARM-subset datapath; successor to the single-cycle decoder.

---
 rtl/ctrl_pkg.sv | 82 ++++++++
 rtl/cond_unit.sv | 31 +++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// ALUControl codes, instruction-field encodings and the ARM condition check.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Data-processing command field, Funct[4:1]
  typedef enum logic [3:0] {
    CMD_AND = 4'b0000,
    CMD_EOR = 4'b0001,
    CMD_SUB = 4'b0010,
    CMD_ADD = 4'b0100,
    CMD_TST = 4'b1000,
    CMD_CMP = 4'b1010,
    CMD_ORR = 4'b1100
  } cmd_t;

  // flags is {N, Z, C, V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic ok;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flags register and condition evaluation. CondEx always reflects the
// registered flags, so an instruction sees the flags left by its predecessor.
module cond_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic       flagw_nz,
  input  logic       flagw_cv,
  output logic [3:0] flags,
  output logic       condex
);

  always_comb begin
    condex = cond_check(cond, flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= FLAG_RST;
    end else begin
      if (flagw_nz && condex) flags[3:2] <= aluflags[3:2];
      if (flagw_cv && condex) flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder and strobe gating.
// Optional CMP/TST support is enabled by defining CMP_TST_EN.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W = 3,
  parameter logic [3:0] FLAG_RST  = 4'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 RegWrite,
  output logic [3:0]           Flags
);

  state_t     state, next_state;
  cmd_t       cmd;
  logic [2:0] dp_alu;
  logic       dp_valid, dp_cv, dp_cmptst;
  logic       next_pc, branch, regw, memw, irw, aluop, in_exec;
  logic       flagw_nz, flagw_cv, condex;

  cond_unit #(.FLAG_RST(FLAG_RST)) u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .cond     (Cond),
    .aluflags (ALUFlags),
    .flagw_nz (flagw_nz),
    .flagw_cv (flagw_cv),
    .flags    (Flags),
    .condex   (condex)
  );

  // Data-processing decode; unknown commands behave as ADD with no side effects
  always_comb begin
    cmd       = cmd_t'(Funct[4:1]);
    dp_alu    = ALU_ADD;
    dp_valid  = 1'b1;
    dp_cv     = 1'b0;
    dp_cmptst = 1'b0;
    case (cmd)
      CMD_ADD: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
      CMD_SUB: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
      CMD_AND: dp_alu = ALU_AND;
      CMD_ORR: dp_alu = ALU_ORR;
      CMD_EOR: dp_alu = ALU_EOR;
`ifdef CMP_TST_EN
      CMD_CMP: begin dp_alu = ALU_SUB; dp_cv = 1'b1; dp_cmptst = 1'b1; end
      CMD_TST: begin dp_alu = ALU_AND; dp_cmptst = 1'b1; end
`endif
      default: begin dp_alu = ALU_ADD; dp_valid = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_pc    = 1'b0;
    branch     = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    aluop      = 1'b0;
    in_exec    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    case (state)
      S_FETCH: begin
        irw        = 1'b1;
        next_pc    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          OP_DP:   next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  next_state = S_MEMADR;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        regw       = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        memw       = 1'b1;
        next_state = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        ALUSrcB    = (state == S_EXECUTEI) ? 2'b01 : 2'b00;
        aluop      = 1'b1;
        in_exec    = 1'b1;
        next_state = dp_cmptst ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = 2'b00;
        regw       = dp_valid;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // Compare/test force a flag write regardless of the S bit
  always_comb begin
    flagw_nz = in_exec & dp_valid & (Funct[0] | dp_cmptst);
    flagw_cv = flagw_nz & dp_cv;
  end

  // Strobes are held low by rst_n directly so none can pulse during reset
  always_comb begin
    ALUControl = ALUCTRL_W'(aluop ? dp_alu : ALU_ADD);
    ImmSrc     = Op;
    RegSrc     = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
    IRWrite    = rst_n & irw;
    RegWrite   = rst_n & regw & condex;
    MemWrite   = rst_n & memw & condex;
    PCWrite    = rst_n & (next_pc | (condex & (branch | (regw & (Rd == 4'hF)))));
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus pushes per-cycle expected
// outputs into a scoreboard; a negedge monitor pops and compares them.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] Flags;

  multicycle_controller #(.ALUCTRL_W(3), .FLAG_RST(4'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Cond       (Cond),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .Flags      (Flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic [1:0] rs;
    logic       regw;
    logic [3:0] fl;
  } exp_t;

  typedef struct {
    exp_t  v;
    string nm;
  } item_t;

  item_t       sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [1:0]  cur_imm, cur_rs;
  logic [3:0]  fprev;

  always @(negedge clk) begin
    item_t it;
    exp_t  act;
    if (sb.size() > 0) begin
      it  = sb.pop_front();
      act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegSrc, RegWrite, Flags};
      n_checks++;
      if (act === it.v) n_pass++;
      else $display("FAIL %s: got %b expected %b (pcw adr memw irw res srca srcb alu imm rs regw nzcv)",
                    it.nm, act, it.v);
    end
  end

  function automatic exp_t mk(input logic pcw, input logic adr, input logic memw, input logic irw,
                              input logic [1:0] res, input logic srca, input logic [1:0] srcb,
                              input logic [2:0] alu, input logic regw, input logic [3:0] fl);
    exp_t e;
    e = {pcw, adr, memw, irw, res, srca, srcb, alu, cur_imm, cur_rs, regw, fl};
    return e;
  endfunction

  task automatic step(input exp_t e, input string nm);
    item_t it;
    it.v  = e;
    it.nm = nm;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] af);
    Cond     = c;
    Op       = op;
    Funct    = f;
    Rd       = rd;
    ALUFlags = af;
    cur_imm  = op;
    cur_rs   = {(op == 2'b01) && !f[0], op == 2'b10};
  endtask

  task automatic fetch(input logic [3:0] fl, input string nm);
    step(mk(1, 0, 0, 1, 2'b10, 1, 2'b10, 3'b000, 0, fl), {nm, ".fetch"});
  endtask

  task automatic decode(input logic [3:0] fl, input string nm);
    step(mk(0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0, fl), {nm, ".decode"});
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(4'hE, 2'b00, 6'b000000, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    // reset: FETCH values with every strobe low
    step(mk(0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0, 4'h0), "reset0");
    step(mk(0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0, 4'h0), "reset1");
    rst_n = 1'b1;

    // ADD immediate, always
    set_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0);
    fetch(4'h0, "addi");
    decode(4'h0, "addi");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 4'h0), "addi.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'h0), "addi.aluwb");

    // LDR
    set_instr(4'hE, 2'b01, 6'b011001, 4'h2, 4'h0);
    fetch(4'h0, "ldr");
    decode(4'h0, "ldr");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 4'h0), "ldr.memadr");
    step(mk(0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'h0), "ldr.memread");
    step(mk(0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000, 1, 4'h0), "ldr.memwb");

    // STR
    set_instr(4'hE, 2'b01, 6'b011000, 4'h2, 4'h0);
    fetch(4'h0, "str");
    decode(4'h0, "str");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 4'h0), "str.memadr");
    step(mk(0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'h0), "str.memwrite");

    // SUBS register with ALU reporting Z; flags change only after the execute edge
    set_instr(4'hE, 2'b00, 6'b000101, 4'h3, 4'b0100);
    fetch(4'h0, "subs");
    decode(4'h0, "subs");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b001, 0, 4'h0), "subs.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'b0100), "subs.aluwb");

    // BEQ taken
    set_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0);
    fetch(4'b0100, "beq");
    decode(4'b0100, "beq");
    step(mk(1, 0, 0, 0, 2'b10, 0, 2'b01, 3'b000, 0, 4'b0100), "beq.branch");

    // BNE not taken
    set_instr(4'h1, 2'b10, 6'b100000, 4'h0, 4'h0);
    fetch(4'b0100, "bne");
    decode(4'b0100, "bne");
    step(mk(0, 0, 0, 0, 2'b10, 0, 2'b01, 3'b000, 0, 4'b0100), "bne.branch");

    // ADD to PC, always
    set_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0);
    fetch(4'b0100, "addpc");
    decode(4'b0100, "addpc");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'b0100), "addpc.exec");
    step(mk(1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'b0100), "addpc.aluwb");

    // ADDS clearing all flags (C,V also written for ADD)
    set_instr(4'hE, 2'b00, 6'b001001, 4'h4, 4'h0);
    fetch(4'b0100, "adds");
    decode(4'b0100, "adds");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'b0100), "adds.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 4'h0), "adds.aluwb");

    // ADDEQ to PC with Z=0: suppressed
    set_instr(4'h0, 2'b00, 6'b001000, 4'hF, 4'h0);
    fetch(4'h0, "addeqpc");
    decode(4'h0, "addeqpc");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'h0), "addeqpc.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'h0), "addeqpc.aluwb");

    // Funct[4:1]=1010 with S=1
    set_instr(4'hE, 2'b00, 6'b010101, 4'h5, 4'b0110);
    fetch(4'h0, "cmp");
    decode(4'h0, "cmp");
`ifdef CMP_TST_EN
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b001, 0, 4'h0), "cmp.exec");
    fprev = 4'b0110;
`else
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'h0), "cmp.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 4'h0), "cmp.aluwb");
    fprev = 4'h0;
`endif

    // EORS: only N,Z updated
    set_instr(4'hE, 2'b00, 6'b000011, 4'h6, 4'b1011);
    fetch(fprev, "eors");
    decode(fprev, "eors");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b100, 0, fprev), "eors.exec");
    fprev = {2'b10, fprev[1:0]};
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, fprev), "eors.aluwb");

    // ORR immediate
    set_instr(4'hE, 2'b00, 6'b111000, 4'h7, 4'h0);
    fetch(fprev, "orri");
    decode(fprev, "orri");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b011, 0, fprev), "orri.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, fprev), "orri.aluwb");

    // AND register
    set_instr(4'hE, 2'b00, 6'b000000, 4'h8, 4'h0);
    fetch(fprev, "and");
    decode(fprev, "and");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, fprev), "and.exec");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, fprev), "and.aluwb");

    // Op=11 NOP: two cycles
    set_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0);
    fetch(fprev, "nop");
    decode(fprev, "nop");

    // LDR interrupted by reset during MEMREAD
    set_instr(4'hE, 2'b01, 6'b011001, 4'h2, 4'h0);
    fetch(fprev, "ldrrst");
    decode(fprev, "ldrrst");
    step(mk(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, fprev), "ldrrst.memadr");
    sb.push_back('{v: mk(0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, fprev), nm: "ldrrst.memread"});
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step(mk(0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0, 4'h0), "ldrrst.inreset");
    rst_n = 1'b1;
    fetch(4'h0, "ldrrst.resume");
    decode(4'h0, "ldrrst.resume");

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
